// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared definitions for the Sobel frame controller: FSM states, default frame size
// and the counter-width helper used by the controller and its position counter.
package sobel_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Frame geometry shared with sobel_kernel
    localparam int DEF_ROWS = 480;
    localparam int DEF_COLS = 360;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_pix_counter.sv
// Row/column position counter for a raster-scanned frame, with clear, increment and a
// flag marking the last pixel of the frame. Also usable by the kernel's data buffer.
module sobel_frame_ctrl_pix_counter
    import sobel_frame_ctrl_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    localparam int ROW_W = cnt_width(ROWS - 1),
    localparam int COL_W = cnt_width(COLS - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic col_wrap;

    assign col_wrap = (col == COL_MAX);
    assign last     = col_wrap && (row == ROW_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_wrap) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel kernel: feeds one frame of source pixels, collects results,
// flags completion or drain timeout. Optional macro SOBEL_CTRL_THRESH_EN binarises results.
module sobel_frame_ctrl
    import sobel_frame_ctrl_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int OUT_PIXELS    = (ROWS - 2) * (COLS - 2),
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pix_valid_i,
    input  logic [7:0] pix_data_i,
    output logic       pix_ready_o,
    output logic [7:0] k_data_o,
    output logic       k_we_o,
    input  logic       k_done_i,
    input  logic [7:0] k_pixel_i,
`ifdef SOBEL_CTRL_THRESH_EN
    input  logic [7:0] threshold_i,
`endif
    output logic       out_valid_o,
    output logic [7:0] out_data_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       err_o
);

    localparam int RES_W = cnt_width(OUT_PIXELS);
    localparam int TMR_W = cnt_width(DRAIN_TIMEOUT - 1);
    localparam logic [RES_W-1:0] RES_FULL = RES_W'(OUT_PIXELS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_t state, state_nxt;

    logic [RES_W-1:0] res_cnt;
    logic [TMR_W-1:0] timer;
    logic [cnt_width(ROWS - 1)-1:0] pix_row;
    logic [cnt_width(COLS - 1)-1:0] pix_col;
    logic pix_last;
    logic accept, start_go, in_frame, cnt_full, counted, surplus, timeout_err;
    logic [7:0] result_pix;
    logic unused_pos;

    assign pix_ready_o  = (state == ST_FEED);
    assign busy_o       = (state != ST_IDLE);
    assign frame_done_o = (state == ST_DONE);

    assign accept      = pix_valid_i && pix_ready_o;
    assign start_go    = start_i && (state == ST_IDLE);
    assign in_frame    = (state == ST_FEED) || (state == ST_DRAIN);
    assign cnt_full    = (res_cnt == RES_FULL);
    assign counted     = k_done_i && in_frame && !cnt_full;
    assign surplus     = k_done_i && !counted;
    // Completion has priority over a timeout landing in the same cycle
    assign timeout_err = (state == ST_DRAIN) && !cnt_full && (timer == TMR_LAST);

    // Position is only needed for the last-pixel flag; row/col stay visible for debug
    assign unused_pos = ^{pix_row, pix_col};

`ifdef SOBEL_CTRL_THRESH_EN
    assign result_pix = (k_pixel_i >= threshold_i) ? 8'hFF : 8'h00;
`else
    assign result_pix = k_pixel_i;
`endif

    sobel_frame_ctrl_pix_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_pix_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_go),
        .inc  (accept),
        .row  (pix_row),
        .col  (pix_col),
        .last (pix_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next-state gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_i) state_nxt = ST_FEED;
            ST_FEED:  if (accept && pix_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (cnt_full || timer == TMR_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_we_o      <= 1'b0;
            k_data_o    <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            res_cnt     <= '0;
            timer       <= '0;
            err_o       <= 1'b0;
        end else begin
            k_we_o      <= accept;
            out_valid_o <= counted;
            if (accept)  k_data_o   <= pix_data_i;
            if (counted) out_data_o <= result_pix;

            if (start_go)     res_cnt <= '0;
            else if (counted) res_cnt <= res_cnt + RES_W'(1);

            // Timer measures idle cycles since the last result, only while draining
            if (state != ST_DRAIN || k_done_i) timer <= '0;
            else                               timer <= timer + TMR_W'(1);

            if (start_go)               err_o <= 1'b0;
            if (surplus || timeout_err) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomised self-checking bench for sobel_frame_ctrl against a frame-level reference model
// (small frame: 4x5, 6 results, drain timeout 8). Follows SOBEL_CTRL_THRESH_EN when defined.
module tb_sobel_frame_ctrl;

    localparam int ROWS          = 4;
    localparam int COLS          = 5;
    localparam int OUT_PIXELS    = 6;
    localparam int DRAIN_TIMEOUT = 8;
    localparam int NPIX          = ROWS * COLS;

    localparam int P_IDLE  = 0;
    localparam int P_FEED  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_data_i = '0;
    logic       k_done_i = 1'b0;
    logic [7:0] k_pixel_i = '0;
    logic       pix_ready_o, k_we_o, out_valid_o, busy_o, frame_done_o, err_o;
    logic [7:0] k_data_o, out_data_o;
`ifdef SOBEL_CTRL_THRESH_EN
    logic [7:0] threshold_i = 8'd12;
`endif

    sobel_frame_ctrl #(
        .ROWS          (ROWS),
        .COLS          (COLS),
        .OUT_PIXELS    (OUT_PIXELS),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .pix_ready_o  (pix_ready_o),
        .k_data_o     (k_data_o),
        .k_we_o       (k_we_o),
        .k_done_i     (k_done_i),
        .k_pixel_i    (k_pixel_i),
`ifdef SOBEL_CTRL_THRESH_EN
        .threshold_i  (threshold_i),
`endif
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Reference model: frame progress as pixel/result totals and idle-cycle run length
    int         m_phase = P_IDLE;
    int         m_acc = 0;
    int         m_res = 0;
    int         m_quiet = 0;
    bit         m_err = 1'b0;
    bit         m_we = 1'b0;
    bit         m_ov = 1'b0;
    logic [7:0] m_kdata = '0;
    logic [7:0] m_od = '0;

    logic [7:0] we_log[$];
    logic [7:0] ov_log[$];
    logic [7:0] sent_pix[$];
    logic [7:0] sent_res[$];
    int fd_count = 0;
    int fd_cyc = 0;
    int last_ov_cyc = 0;
    int res_sent = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] expect_pix(input logic [7:0] p);
`ifdef SOBEL_CTRL_THRESH_EN
        return (p >= threshold_i) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    task automatic model_step();
        bit acc, in_frame, cnt;
        if (rst) begin
            m_phase = P_IDLE; m_acc = 0; m_res = 0; m_quiet = 0;
            m_err = 0; m_we = 0; m_ov = 0; m_kdata = '0; m_od = '0;
            return;
        end
        acc      = pix_valid_i && (m_phase == P_FEED);
        in_frame = (m_phase == P_FEED) || (m_phase == P_DRAIN);
        cnt      = k_done_i && in_frame && (m_res < OUT_PIXELS);
        m_we = acc;
        if (acc) m_kdata = pix_data_i;
        m_ov = cnt;
        if (cnt) m_od = expect_pix(k_pixel_i);
        case (m_phase)
            P_IDLE: if (start_i) begin
                m_phase = P_FEED; m_err = 0; m_acc = 0; m_res = 0; m_quiet = 0;
            end
            P_FEED: if (acc) begin
                m_acc++;
                if (m_acc == NPIX) begin m_phase = P_DRAIN; m_quiet = 0; end
            end
            P_DRAIN: begin
                if (m_res == OUT_PIXELS) m_phase = P_DONE;
                else if (m_quiet == DRAIN_TIMEOUT - 1) begin m_phase = P_DONE; m_err = 1; end
                m_quiet = k_done_i ? 0 : m_quiet + 1;
            end
            default: m_phase = P_IDLE;
        endcase
        if (cnt) m_res++;
        if (k_done_i && !cnt) m_err = 1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check("busy",       32'(busy_o),       32'(m_phase != P_IDLE));
            check("pix_ready",  32'(pix_ready_o),  32'(m_phase == P_FEED));
            check("frame_done", 32'(frame_done_o), 32'(m_phase == P_DONE));
            check("err",        32'(err_o),        32'(m_err));
            check("k_we",       32'(k_we_o),       32'(m_we));
            check("k_data",     32'(k_data_o),     32'(m_kdata));
            check("out_valid",  32'(out_valid_o),  32'(m_ov));
            check("out_data",   32'(out_data_o),   32'(m_od));
        end
        if (k_we_o === 1'b1) we_log.push_back(k_data_o);
        if (out_valid_o === 1'b1) begin
            ov_log.push_back(out_data_o);
            last_ov_cyc = cyc;
        end
        if (frame_done_o === 1'b1) begin
            fd_count++;
            fd_cyc = cyc;
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        we_log.delete(); ov_log.delete(); sent_pix.delete(); sent_res.delete();
        fd_count = 0;
        res_sent = 0;
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
    task automatic feed(input int mode, input int n_acc, input int n_feed_res,
                        input bit poke_start, input bit seq);
        int acc = 0;
        int guard = 0;
        logic [7:0] d;
        d = seq ? 8'd0 : 8'($urandom);
        while (acc < n_acc && guard < 500) begin
            case (mode)
                0:       pix_valid_i = 1'b1;
                1:       pix_valid_i = ~guard[0];
                default: pix_valid_i = 1'($urandom_range(0, 1));
            endcase
            pix_data_i = d;
            k_done_i = 1'b0;
            if (res_sent < n_feed_res && $urandom_range(0, 2) == 0) begin
                k_done_i  = 1'b1;
                k_pixel_i = 8'($urandom);
                sent_res.push_back(expect_pix(k_pixel_i));
                res_sent++;
            end
            start_i = poke_start && (acc == 5);
            if (pix_valid_i && pix_ready_o) begin
                sent_pix.push_back(d);
                acc++;
                d = seq ? d + 8'd1 : 8'($urandom);
            end
            tick();
            guard++;
        end
        check("feed_accepts", 32'(acc), 32'(n_acc));
        pix_valid_i = 1'b0;
        k_done_i    = 1'b0;
        start_i     = 1'b0;
    endtask

    task automatic drain(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            k_done_i = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            k_done_i  = 1'b1;
            k_pixel_i = seq ? 8'(10 + i) : 8'($urandom);
            sent_res.push_back(expect_pix(k_pixel_i));
            res_sent++;
            tick();
        end
        k_done_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64; i++) begin
            if (frame_done_o === 1'b1) break;
            tick();
        end
        check("frame_done_seen", 32'(frame_done_o), 32'd1);
        tick();
    endtask

    task automatic end_frame(input bit exp_err);
        check("we_count", 32'(we_log.size()), 32'(NPIX));
        for (int i = 0; i < sent_pix.size() && i < we_log.size(); i++)
            check("we_order", 32'(we_log[i]), 32'(sent_pix[i]));
        check("out_count", 32'(ov_log.size()), 32'(sent_res.size()));
        for (int i = 0; i < sent_res.size() && i < ov_log.size(); i++)
            check("out_order", 32'(ov_log[i]), 32'(sent_res[i]));
        check("frame_done_pulses", 32'(fd_count), 32'd1);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("err_after_frame", 32'(err_o), 32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy_o),       32'd0);
        check({tag, "_ready"},     32'(pix_ready_o),  32'd0);
        check({tag, "_k_we"},      32'(k_we_o),       32'd0);
        check({tag, "_k_data"},    32'(k_data_o),     32'd0);
        check({tag, "_out_valid"}, 32'(out_valid_o),  32'd0);
        check({tag, "_out_data"},  32'(out_data_o),   32'd0);
        check({tag, "_done"},      32'(frame_done_o), 32'd0);
        check({tag, "_err"},       32'(err_o),        32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Back-to-back pixels 0..19, then results 10..15 after the feed
        new_frame();
        start_frame();
        feed(0, NPIX, 0, 1'b0, 1'b1);
        check("ready_drop_after_last", 32'(pix_ready_o), 32'd0);
        drain(OUT_PIXELS, 1'b1);
        wait_done();
        end_frame(1'b0);

        // Valid every other cycle, some results arrive while still feeding
        new_frame();
        start_frame();
        feed(1, NPIX, 2, 1'b0, 1'b0);
        drain(OUT_PIXELS - res_sent, 1'b0);
        wait_done();
        end_frame(1'b0);

        // Only 4 results, then silence: timeout
        new_frame();
        start_frame();
        feed(2, NPIX, 0, 1'b0, 1'b0);
        drain(4, 1'b0);
        wait_done();
        end_frame(1'b1);
        check("timeout_gap", 32'(fd_cyc - last_ov_cyc), 32'(DRAIN_TIMEOUT));

        // Next start clears the sticky error
        new_frame();
        start_frame();
        check("err_cleared_by_start", 32'(err_o), 32'd0);
        feed(2, NPIX, 3, 1'b0, 1'b0);
        drain(OUT_PIXELS - res_sent, 1'b0);
        wait_done();
        end_frame(1'b0);

        // start_i during FEED is ignored, then a surplus result after completion
        new_frame();
        start_frame();
        feed(0, NPIX, 0, 1'b1, 1'b0);
        drain(OUT_PIXELS, 1'b0);
        wait_done();
        end_frame(1'b0);
        k_done_i  = 1'b1;
        k_pixel_i = 8'($urandom);
        tick();
        k_done_i = 1'b0;
        tick();
        tick();
        check("surplus_err", 32'(err_o), 32'd1);
        check("surplus_no_out", 32'(ov_log.size()), 32'(OUT_PIXELS));

        // Reset after 9 accepts, then a clean frame
        new_frame();
        start_frame();
        feed(2, 9, 0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        tick();
        new_frame();
        start_frame();
        feed(2, NPIX, 2, 1'b0, 1'b0);
        drain(OUT_PIXELS - res_sent, 1'b0);
        wait_done();
        end_frame(1'b0);

        // A few fully random frames
        for (int f = 0; f < 4; f++) begin
            new_frame();
            start_frame();
            feed($urandom_range(0, 2), NPIX, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            drain(OUT_PIXELS - res_sent, 1'b0);
            wait_done();
            end_frame(1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
